// File: rtl/id_opimm_pkg.sv
// Shared decode constants and ALU op encoding for the ID stage and its helpers.
// Pure definitions: no latency, no flow control.
package id_opimm_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RADDR_W_DEF = 5;

    localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADDI  = 3'b000;
    localparam logic [2:0] F3_SLLI  = 3'b001;
    localparam logic [2:0] F3_SLTI  = 3'b010;
    localparam logic [2:0] F3_SLTIU = 3'b011;
    localparam logic [2:0] F3_XORI  = 3'b100;
    localparam logic [2:0] F3_SRXI  = 3'b101;
    localparam logic [2:0] F3_ORI   = 3'b110;
    localparam logic [2:0] F3_ANDI  = 3'b111;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SLT  = 4'd1,
        ALU_SLTU = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_AND  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8
    } alu_op_e;

endpackage

// File: rtl/id_opimm_pipe_fwd_mux.sv
// rs1 operand select (EX > MEM > RF, x0 forced to zero) plus load-use hazard flag.
// Combinational, no latency; hazard is the only backpressure it produces.
module id_fwd_mux #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int FWD_EN  = 1
) (
    input  logic               req,
    input  logic [RADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]    rf_data,
    input  logic               ex_we,
    input  logic [RADDR_W-1:0] ex_waddr,
    input  logic [XLEN-1:0]    ex_wdata,
    input  logic               ex_is_load,
    input  logic               mem_we,
    input  logic [RADDR_W-1:0] mem_waddr,
    input  logic [XLEN-1:0]    mem_wdata,
    output logic [XLEN-1:0]    operand,
    output logic               hazard
);

    localparam bit FWD = (FWD_EN != 0);

    logic rs_nz;
    logic ex_hit;
    logic mem_hit;

    assign rs_nz   = (rs_addr != '0);
    assign ex_hit  = FWD && ex_we  && (ex_waddr  == rs_addr);
    assign mem_hit = FWD && mem_we && (mem_waddr == rs_addr);

    // A load in EX has no data yet, so matching it must stall instead of bypass.
    assign hazard = req && ex_is_load && ex_we && (ex_waddr == rs_addr) && rs_nz;

    always_comb begin
        operand = rf_data;
        if (!rs_nz) begin
            operand = '0;
        end else if (ex_hit) begin
            operand = ex_wdata;
        end else if (mem_hit) begin
            operand = mem_wdata;
        end
    end

endmodule

// File: rtl/id_opimm_pipe.sv
// OP-IMM decode stage feeding a registered ID/EX slot; accepted instructions appear one clk later.
// Slot advances when empty or consumed; load-use stalls hold the instruction upstream, flush wins.
module id_opimm_pipe
    import id_opimm_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int FWD_EN  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        inst_i,
    input  logic               inst_valid_i,
    output logic               inst_ready_o,
    input  logic               flush_i,
    output logic [RADDR_W-1:0] reg1_raddr_o,
    output logic               reg1_re_o,
    input  logic [XLEN-1:0]    reg1_rdata_i,
    input  logic               ex_we_i,
    input  logic [RADDR_W-1:0] ex_waddr_i,
    input  logic [XLEN-1:0]    ex_wdata_i,
    input  logic               ex_is_load_i,
    input  logic               mem_we_i,
    input  logic [RADDR_W-1:0] mem_waddr_i,
    input  logic [XLEN-1:0]    mem_wdata_i,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    output alu_op_e            alu_op_o,
    output logic [XLEN-1:0]    op1_o,
    output logic [XLEN-1:0]    op2_o,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic               illegal_o
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] rs1_val;
    logic            is_opimm;
    logic            hazard;
    logic            adv;
    logic            take;
    alu_op_e         dec_alu;
    logic [XLEN-1:0] dec_op2;
    logic            dec_ill;

    assign opcode   = inst_i[6:0];
    assign funct3   = inst_i[14:12];
    assign rd       = inst_i[11:7];
    assign imm      = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign shamt    = XLEN'(inst_i[20 +: SHAMT_W]);
    assign is_opimm = (opcode == OPCODE_OPIMM);

    assign reg1_raddr_o = RADDR_W'(inst_i[19:15]);
    assign reg1_re_o    = is_opimm;

    id_fwd_mux #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W),
        .FWD_EN  (FWD_EN)
    ) u_fwd (
        .req        (inst_valid_i),
        .rs_addr    (reg1_raddr_o),
        .rf_data    (reg1_rdata_i),
        .ex_we      (ex_we_i),
        .ex_waddr   (ex_waddr_i),
        .ex_wdata   (ex_wdata_i),
        .ex_is_load (ex_is_load_i),
        .mem_we     (mem_we_i),
        .mem_waddr  (mem_waddr_i),
        .mem_wdata  (mem_wdata_i),
        .operand    (rs1_val),
        .hazard     (hazard)
    );

    // Shift encodings: bits above the shamt field must be clear (bit 30 selects SRA).
    always_comb begin
        dec_alu = ALU_ADD;
        dec_op2 = imm;
        dec_ill = 1'b0;
        if (!is_opimm) begin
            dec_ill = 1'b1;
        end else begin
            case (funct3)
                F3_ADDI:  dec_alu = ALU_ADD;
                F3_SLTI:  dec_alu = ALU_SLT;
                F3_SLTIU: dec_alu = ALU_SLTU;
                F3_XORI:  dec_alu = ALU_XOR;
                F3_ORI:   dec_alu = ALU_OR;
                F3_ANDI:  dec_alu = ALU_AND;
                F3_SLLI: begin
                    dec_alu = ALU_SLL;
                    dec_op2 = shamt;
                    dec_ill = |inst_i[31:20+SHAMT_W];
                end
                F3_SRXI: begin
                    dec_alu = inst_i[30] ? ALU_SRA : ALU_SRL;
                    dec_op2 = shamt;
                    dec_ill = inst_i[31] | (|inst_i[29:20+SHAMT_W]);
                end
            endcase
        end
    end

    assign adv          = !ex_valid_o || ex_ready_i;
    assign take         = adv && inst_valid_i && !hazard;
    assign inst_ready_o = flush_i || (adv && !hazard);

    // Bubbles and flushes clear the whole slot so no stale operands linger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_o  <= 1'b0;
            alu_op_o    <= ALU_ADD;
            op1_o       <= '0;
            op2_o       <= '0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            illegal_o   <= 1'b0;
        end else if (flush_i || adv) begin
            if (take && !flush_i) begin
                ex_valid_o  <= 1'b1;
                alu_op_o    <= dec_alu;
                op1_o       <= dec_ill ? '0 : rs1_val;
                op2_o       <= dec_ill ? '0 : dec_op2;
                reg_we_o    <= !dec_ill && (rd != ZERO_REG);
                reg_waddr_o <= RADDR_W'(rd);
                illegal_o   <= dec_ill;
            end else begin
                ex_valid_o  <= 1'b0;
                alu_op_o    <= ALU_ADD;
                op1_o       <= '0;
                op2_o       <= '0;
                reg_we_o    <= 1'b0;
                reg_waddr_o <= '0;
                illegal_o   <= 1'b0;
            end
        end
    end

endmodule
